// File: rtl/uvc_frame_buffer_manager.sv
// Triple-buffer arbiter handing DDR3 frame base addresses to the capture writer and UVC streamer.
// Writer, reader and spare roles rotate over three fixed buffers; the spare holds the latest completed frame.
module uvc_frame_buffer_manager #(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] BUF_BASE_ADDR = 32'h8100_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE    = 32'h0010_0000,
    parameter int                CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              wr_frame_done,
    output logic [ADDR_W-1:0] wr_buffer_addr,
    input  logic              rd_next_req,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] rd_buffer_addr,
    output logic              rd_new_frame,
    output logic [CNT_W-1:0]  dropped_cnt,
    output logic [CNT_W-1:0]  repeated_cnt,
    input  logic              clear_stats
);

    localparam logic [ADDR_W-1:0] ADDR0     = BUF_BASE_ADDR;
    localparam logic [ADDR_W-1:0] ADDR1     = BUF_BASE_ADDR + BUF_STRIDE;
    localparam logic [ADDR_W-1:0] ADDR2     = ADDR1 + BUF_STRIDE;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] w_idx_r, r_idx_r, s_idx_r;
    logic       fresh_r;
    logic [1:0] w_nxt_s, r_nxt_s, s_nxt_s;
    logic       fresh_nxt_s;
    logic       commit_s;
    logic       ack_nxt_s;
    logic       new_frame_nxt_s;
    logic       drop_inc_s;
    logic       rep_inc_s;

    // Index 3 never occurs because the role indices always form a permutation of {0,1,2}.
    function automatic logic [ADDR_W-1:0] idx_to_addr(input logic [1:0] idx);
        logic [ADDR_W-1:0] addr;
        case (idx)
            2'd0:    addr = ADDR0;
            2'd1:    addr = ADDR1;
            2'd2:    addr = ADDR2;
            default: addr = ADDR0;
        endcase
        return addr;
    endfunction

    function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic clr);
        logic [CNT_W-1:0] res;
        if (clr) begin
            res = CNT_ZERO;
        end else if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    assign commit_s = wr_frame_done & ~freeze;

    // Role rotation and statistic increments for this cycle's events.
    always_comb begin
        w_nxt_s         = w_idx_r;
        r_nxt_s         = r_idx_r;
        s_nxt_s         = s_idx_r;
        fresh_nxt_s     = fresh_r;
        ack_nxt_s       = 1'b0;
        new_frame_nxt_s = rd_new_frame;
        drop_inc_s      = 1'b0;
        rep_inc_s       = 1'b0;
        case ({commit_s, rd_next_req})
            2'b10: begin
                w_nxt_s     = s_idx_r;
                s_nxt_s     = w_idx_r;
                fresh_nxt_s = 1'b1;
                drop_inc_s  = fresh_r;
            end
            2'b01: begin
                ack_nxt_s = 1'b1;
                if (fresh_r) begin
                    r_nxt_s         = s_idx_r;
                    s_nxt_s         = r_idx_r;
                    fresh_nxt_s     = 1'b0;
                    new_frame_nxt_s = 1'b1;
                end else begin
                    new_frame_nxt_s = 1'b0;
                    rep_inc_s       = 1'b1;
                end
            end
            2'b11: begin
                // The frame just finished goes straight to the reader; any unread spare is lost.
                r_nxt_s         = w_idx_r;
                w_nxt_s         = s_idx_r;
                s_nxt_s         = r_idx_r;
                fresh_nxt_s     = 1'b0;
                ack_nxt_s       = 1'b1;
                new_frame_nxt_s = 1'b1;
                drop_inc_s      = fresh_r;
            end
            default: begin
                fresh_nxt_s = fresh_r;
            end
        endcase
    end

    // Role state, registered addresses, handshake and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx_r        <= 2'd0;
            r_idx_r        <= 2'd1;
            s_idx_r        <= 2'd2;
            fresh_r        <= 1'b0;
            wr_buffer_addr <= ADDR0;
            rd_buffer_addr <= ADDR1;
            rd_ack         <= 1'b0;
            rd_new_frame   <= 1'b0;
            dropped_cnt    <= CNT_ZERO;
            repeated_cnt   <= CNT_ZERO;
        end else begin
            w_idx_r        <= w_nxt_s;
            r_idx_r        <= r_nxt_s;
            s_idx_r        <= s_nxt_s;
            fresh_r        <= fresh_nxt_s;
            wr_buffer_addr <= idx_to_addr(w_nxt_s);
            rd_buffer_addr <= idx_to_addr(r_nxt_s);
            rd_ack         <= ack_nxt_s;
            rd_new_frame   <= new_frame_nxt_s;
            dropped_cnt    <= stat_next(dropped_cnt, drop_inc_s, clear_stats);
            repeated_cnt   <= stat_next(repeated_cnt, rep_inc_s, clear_stats);
        end
    end

endmodule

// File: tb/tb_uvc_frame_buffer_manager.sv
// Bench for uvc_frame_buffer_manager: directed vector table, hand sequences, and a randomized
// run against a buffer-ownership reference model.
module tb_uvc_frame_buffer_manager;

    localparam logic [31:0] A0 = 32'h8100_0000;
    localparam logic [31:0] A1 = 32'h8110_0000;
    localparam logic [31:0] A2 = 32'h8120_0000;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        wr_frame_done;
    logic [31:0] wr_buffer_addr;
    logic        rd_next_req;
    logic        rd_ack;
    logic [31:0] rd_buffer_addr;
    logic        rd_new_frame;
    logic [15:0] dropped_cnt;
    logic [15:0] repeated_cnt;
    logic        clear_stats;

    int checks;
    int errors;

    uvc_frame_buffer_manager dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .wr_frame_done  (wr_frame_done),
        .wr_buffer_addr (wr_buffer_addr),
        .rd_next_req    (rd_next_req),
        .rd_ack         (rd_ack),
        .rd_buffer_addr (rd_buffer_addr),
        .rd_new_frame   (rd_new_frame),
        .dropped_cnt    (dropped_cnt),
        .repeated_cnt   (repeated_cnt),
        .clear_stats    (clear_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          wfd;
        bit          req;
        bit          frz;
        bit          clr;
        logic [31:0] exp_wr;
        logic [31:0] exp_rd;
        bit          exp_ack;
        bit          exp_new;
        int          exp_drop;
        int          exp_rep;
    } vec_t;

    vec_t vecs[21];

    // Reference model: which role (0 writer, 1 reader, 2 spare) each physical buffer has.
    int m_owner[3];
    bit m_fresh;
    bit m_ack;
    bit m_new;
    int m_drop;
    int m_rep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit wfd, input bit req, input bit frz, input bit clr);
        wr_frame_done = wfd;
        rd_next_req   = req;
        freeze        = frz;
        clear_stats   = clr;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner[0] = 0;
        m_owner[1] = 1;
        m_owner[2] = 2;
        m_fresh = 1'b0;
        m_ack = 1'b0;
        m_new = 1'b0;
        m_drop = 0;
        m_rep = 0;
    endtask

    function automatic int buf_of(input int role);
        int r;
        r = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_owner[i] == role) r = i;
        end
        return r;
    endfunction

    function automatic logic [31:0] addr_of(input int role);
        return 32'h8100_0000 + 32'(buf_of(role)) * 32'h0010_0000;
    endfunction

    task automatic model_step(input bit wfd, input bit req, input bit frz, input bit clr);
        bit d;
        int bw;
        int br;
        int bs;
        d  = wfd && !frz;
        bw = buf_of(0);
        br = buf_of(1);
        bs = buf_of(2);
        m_ack = req;
        if (d && !req) begin
            if (m_fresh) m_drop++;
            m_owner[bw] = 2;
            m_owner[bs] = 0;
            m_fresh = 1'b1;
        end else if (req && !d) begin
            if (m_fresh) begin
                m_owner[br] = 2;
                m_owner[bs] = 1;
                m_fresh = 1'b0;
                m_new = 1'b1;
            end else begin
                m_new = 1'b0;
                m_rep++;
            end
        end else if (req && d) begin
            if (m_fresh) m_drop++;
            m_owner[bw] = 1;
            m_owner[bs] = 0;
            m_owner[br] = 2;
            m_fresh = 1'b0;
            m_new = 1'b1;
        end
        if (m_drop > 65535) m_drop = 65535;
        if (m_rep > 65535) m_rep = 65535;
        if (clr) begin
            m_drop = 0;
            m_rep = 0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //            rst wfd req frz clr  wr  rd  ack new drop rep
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A2, A1, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A2, A1, 1'b0, 1'b0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A2, A0, 1'b1, 1'b1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A2, A0, 1'b0, 1'b1, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0, A1, 1'b1, 1'b0, 0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0, A1, 1'b0, 1'b0, 0, 1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A2, A1, 1'b0, 1'b0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A0, A1, 1'b0, 1'b0, 1, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A2, A1, 1'b0, 1'b0, 2, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A2, A1, 1'b0, 1'b0, 2, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A2, A0, 1'b1, 1'b1, 2, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A2, A0, 1'b0, 1'b1, 2, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A2, A0, 1'b1, 1'b1, 0, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A2, A0, 1'b0, 1'b1, 0, 0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0, A1, 1'b1, 1'b0, 0, 1};

        do_reset();
        chk("reset_wr_addr", wr_buffer_addr, A0);
        chk("reset_rd_addr", rd_buffer_addr, A1);
        chk("reset_ack", {31'd0, rd_ack}, 32'd0);
        chk("reset_new", {31'd0, rd_new_frame}, 32'd0);
        chk("reset_drop", {16'd0, dropped_cnt}, 32'd0);
        chk("reset_rep", {16'd0, repeated_cnt}, 32'd0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].wfd, vecs[i].req, vecs[i].frz, vecs[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wr", i), wr_buffer_addr, vecs[i].exp_wr);
            chk($sformatf("vec%0d_rd", i), rd_buffer_addr, vecs[i].exp_rd);
            chk($sformatf("vec%0d_ack", i), {31'd0, rd_ack}, {31'd0, vecs[i].exp_ack});
            chk($sformatf("vec%0d_new", i), {31'd0, rd_new_frame}, {31'd0, vecs[i].exp_new});
            chk($sformatf("vec%0d_drop", i), {16'd0, dropped_cnt}, 32'(vecs[i].exp_drop));
            chk($sformatf("vec%0d_rep", i), {16'd0, repeated_cnt}, 32'(vecs[i].exp_rep));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation: 65536 consecutive completions yield 65535 drops.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) @(posedge clk);
        #1;
        chk("drop_at_max", {16'd0, dropped_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        chk("drop_saturated", {16'd0, dropped_cnt}, 32'h0000_FFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("clear_beats_drop", {16'd0, dropped_cnt}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted while a request is pending.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_wr", wr_buffer_addr, A2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr", wr_buffer_addr, A0);
        chk("async_rst_rd", rd_buffer_addr, A1);
        chk("async_rst_ack", {31'd0, rd_ack}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_ack", {31'd0, rd_ack}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("lost_req_ack", {31'd0, rd_ack}, 32'd0);
        chk("lost_req_rd", rd_buffer_addr, A1);

        // Randomized run against the ownership model.
        do_reset();
        model_reset();
        begin
            bit last_req;
            bit wfd;
            bit req;
            bit frz;
            bit clr;
            last_req = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                wfd = ($urandom_range(0, 1) == 1);
                frz = ($urandom_range(0, 3) == 0);
                clr = ($urandom_range(0, 49) == 0);
                req = !last_req && ($urandom_range(0, 2) == 0);
                last_req = req;
                drive(wfd, req, frz, clr);
                @(posedge clk);
                #1;
                model_step(wfd, req, frz, clr);
                chk("rand_wr", wr_buffer_addr, addr_of(0));
                chk("rand_rd", rd_buffer_addr, addr_of(1));
                chk("rand_ack", {31'd0, rd_ack}, {31'd0, m_ack});
                chk("rand_new", {31'd0, rd_new_frame}, {31'd0, m_new});
                chk("rand_drop", {16'd0, dropped_cnt}, 32'(m_drop));
                chk("rand_rep", {16'd0, repeated_cnt}, 32'(m_rep));
                if (wr_buffer_addr == rd_buffer_addr) begin
                    errors++;
                    $display("FAIL rand_wr_ne_rd: both %h at %0t", wr_buffer_addr, $time);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
